// File: rtl/order_tx_serializer_if.sv
// Approved-order input bundle plus the byte-wide valid/ready egress stream of order_tx_serializer.
// master drives orders and tx_ready; slave is the serializer.
interface order_tx_serializer_if #(
    parameter int PRICE_W = 32,
    parameter int SIZE_W  = 32,
    parameter int TS_W    = 64
);
    logic               valid_in;
    logic               side_in;
    logic [PRICE_W-1:0] price_in;
    logic [SIZE_W-1:0]  qty_in;
    logic [TS_W-1:0]    ts_in;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               tx_last;

    modport master (
        output valid_in, side_in, price_in, qty_in, ts_in, tx_ready,
        input  tx_data, tx_valid, tx_last
    );

    modport slave (
        input  valid_in, side_in, price_in, qty_in, ts_in, tx_ready,
        output tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/order_tx_serializer.sv
// Buffers approved orders in a FIFO, tags them with sequential IDs and serialises each as a byte message.
// Define ORDER_TX_CHECKSUM_EN to append the XOR checksum byte (17-byte message instead of 16).
module order_tx_serializer #(
    parameter int          ORDER_FIFO_DEPTH = 4,
    parameter logic [15:0] ORDER_ID_INIT    = 16'h0000,
    parameter int          PRICE_W          = 32,
    parameter int          SIZE_W           = 32,
    parameter int          TS_W             = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    order_tx_serializer_if.slave              bus,
    output logic                              busy,
    output logic [$clog2(ORDER_FIFO_DEPTH):0] fifo_count,
    output logic                              drop_pulse,
    output logic [15:0]                       drop_count,
    output logic [15:0]                       next_order_id
);
    localparam int         AW       = $clog2(ORDER_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(ORDER_FIFO_DEPTH);
`ifdef ORDER_TX_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif

    generate
        if (PRICE_W > 32 || SIZE_W > 32) begin : g_bad_width
            $error("order_tx_serializer: PRICE_W and SIZE_W must not exceed 32");
        end
        if (ORDER_FIFO_DEPTH < 2 || (ORDER_FIFO_DEPTH & (ORDER_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("order_tx_serializer: ORDER_FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef struct packed {
        logic        side;
        logic [15:0] id;
        logic [31:0] price;
        logic [31:0] qty;
        logic [31:0] ts;
    } order_t;

    typedef enum logic {IDLE, SEND} state_t;

    order_t         mem [ORDER_FIFO_DEPTH];
    order_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    state_t         state;
    logic [127:0]   msg;
    logic [4:0]     byte_idx;
`ifdef ORDER_TX_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
    assign pop  = (state == IDLE) && (fifo_count != '0);
    assign push = bus.valid_in && ((fifo_count != FULL_CNT) || pop);
    assign head = mem[rd_ptr];
    assign busy = (fifo_count != '0) || (state == SEND);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{side:  bus.side_in,
                             id:    next_order_id,
                             price: 32'(bus.price_in),
                             qty:   32'(bus.qty_in),
                             ts:    32'(bus.ts_in)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_order_id <= ORDER_ID_INIT;
            drop_pulse    <= 1'b0;
            drop_count    <= '0;
        end else begin
            drop_pulse <= bus.valid_in && !push;
            if (bus.valid_in && !push && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (push) begin
                next_order_id <= next_order_id + 16'd1;
            end
        end
    end

    // The message register shifts left one byte per accepted byte; its top byte is always the next to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            msg          <= '0;
            byte_idx     <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
`ifdef ORDER_TX_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        msg          <= {8'hA5, 7'b0, head.side, head.id, head.price, head.qty, head.ts};
                        byte_idx     <= '0;
                        bus.tx_data  <= 8'hA5;
                        bus.tx_valid <= 1'b1;
                        bus.tx_last  <= 1'b0;
`ifdef ORDER_TX_CHECKSUM_EN
                        csum         <= '0;
`endif
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (bus.tx_last) begin
                            bus.tx_valid <= 1'b0;
                            bus.tx_last  <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            byte_idx    <= byte_idx + 5'd1;
                            msg         <= msg << 8;
                            bus.tx_last <= (byte_idx + 5'd1 == LAST_IDX);
`ifdef ORDER_TX_CHECKSUM_EN
                            csum        <= csum ^ bus.tx_data;
                            bus.tx_data <= (byte_idx == 5'd15) ? (csum ^ bus.tx_data) : msg[119:112];
`else
                            bus.tx_data <= msg[119:112];
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_order_tx_serializer.sv
// Randomised self-checking bench for order_tx_serializer against a byte-queue message model.
// Honours ORDER_TX_CHECKSUM_EN the same way the design does.
module tb_order_tx_serializer;
    localparam int DEPTH   = 4;
    localparam int PRICE_W = 24;
    localparam int SIZE_W  = 20;
    localparam int TS_W    = 40;
`ifdef ORDER_TX_CHECKSUM_EN
    localparam int MSG_LEN = 17;
`else
    localparam int MSG_LEN = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, drop_pulse, busy_w, drop_pulse_w;
    logic [2:0]  fifo_count, fifo_count_w;
    logic [15:0] drop_count, next_order_id, drop_count_w, next_order_id_w;

    always #5 clk = ~clk;

    order_tx_serializer_if #(.PRICE_W(PRICE_W), .SIZE_W(SIZE_W), .TS_W(TS_W)) bus ();
    order_tx_serializer_if #(.PRICE_W(PRICE_W), .SIZE_W(SIZE_W), .TS_W(TS_W)) bus_w ();

    order_tx_serializer #(.ORDER_FIFO_DEPTH(DEPTH), .ORDER_ID_INIT(16'h0000),
                          .PRICE_W(PRICE_W), .SIZE_W(SIZE_W), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .fifo_count(fifo_count),
        .drop_pulse(drop_pulse), .drop_count(drop_count), .next_order_id(next_order_id)
    );

    order_tx_serializer #(.ORDER_FIFO_DEPTH(DEPTH), .ORDER_ID_INIT(16'hFFFF),
                          .PRICE_W(PRICE_W), .SIZE_W(SIZE_W), .TS_W(TS_W)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w), .busy(busy_w), .fifo_count(fifo_count_w),
        .drop_pulse(drop_pulse_w), .drop_count(drop_count_w), .next_order_id(next_order_id_w)
    );

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  exp_data [$];
    bit          exp_last [$];
    logic [15:0] model_id = 16'h0000;
    int          accepted_cnt = 0;
    int          completed_cnt = 0;
    logic [7:0]  w_bytes [$];
    logic [7:0]  basic_bytes [17] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34,
                                      8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'hF4};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference message: sync, side, ID, zero-extended price/qty, low 32 timestamp bits, optional XOR.
    function automatic void model_push(input bit side, input logic [PRICE_W-1:0] price,
                                       input logic [SIZE_W-1:0] qty, input logic [TS_W-1:0] ts);
        logic [7:0]  b [MSG_LEN];
        logic [31:0] p, q, t;
        logic [7:0]  x;
        p = 32'(price);
        q = 32'(qty);
        t = ts[31:0];
        b[0] = 8'hA5;
        b[1] = {7'b0, side};
        b[2] = model_id[15:8];
        b[3] = model_id[7:0];
        for (int i = 0; i < 4; i++) begin
            b[4 + i]  = p[31 - 8*i -: 8];
            b[8 + i]  = q[31 - 8*i -: 8];
            b[12 + i] = t[31 - 8*i -: 8];
        end
        x = 8'h00;
        for (int i = 0; i < 16; i++) x = x ^ b[i];
        if (MSG_LEN == 17) b[MSG_LEN-1] = x;
        for (int i = 0; i < MSG_LEN; i++) begin
            exp_data.push_back(b[i]);
            exp_last.push_back(i == MSG_LEN - 1);
        end
        model_id = model_id + 16'd1;
        accepted_cnt++;
    endfunction

    function automatic void push_literal();
        for (int i = 0; i < MSG_LEN; i++) begin
            exp_data.push_back(basic_bytes[i]);
            exp_last.push_back(i == MSG_LEN - 1);
        end
        model_id = model_id + 16'd1;
        accepted_cnt++;
    endfunction

    function automatic void model_flush();
        exp_data.delete();
        exp_last.delete();
        model_id = 16'h0000;
        accepted_cnt = 0;
        completed_cnt = 0;
    endfunction

    // Stream monitor: every accepted byte must be the next model byte; stalled bytes must hold.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        logic [7:0] ed;
        bit         el;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                checkOutput("stall_hold", {22'b0, bus.tx_valid, bus.tx_last, bus.tx_data},
                            {22'b0, 1'b1, prev_last, prev_data});
            if (bus.tx_valid && bus.tx_ready) begin
                checkOutput("byte_expected", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0) begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checkOutput("tx_data", 32'(bus.tx_data), 32'(ed));
                    checkOutput("tx_last", 32'(bus.tx_last), 32'(el));
                    if (el) completed_cnt++;
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_last  = bus.tx_last;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_w.tx_valid && bus_w.tx_ready) w_bytes.push_back(bus_w.tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input bit side, input logic [PRICE_W-1:0] price,
                                 input logic [SIZE_W-1:0] qty, input logic [TS_W-1:0] ts);
        bus.valid_in = v;
        bus.side_in  = side;
        bus.price_in = price;
        bus.qty_in   = qty;
        bus.ts_in    = ts;
    endtask

    task automatic rand_order(output bit side, output logic [PRICE_W-1:0] price,
                              output logic [SIZE_W-1:0] qty, output logic [TS_W-1:0] ts);
        logic [31:0] r0, r1, r2, r3;
        r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
        side  = r0[31];
        price = r0[PRICE_W-1:0];
        qty   = r1[SIZE_W-1:0];
        ts    = {r2[7:0], r3};
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_data.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", 32'(exp_data.size()), 32'd0);
        tick();
        tick();
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(0, 0, '0, '0, '0);
        model_flush();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit                 s;
        logic [PRICE_W-1:0] p;
        logic [SIZE_W-1:0]  q;
        logic [TS_W-1:0]    t;
        int                 n;

        applyStimulus(0, 0, '0, '0, '0);
        bus.tx_ready   = 1'b1;
        bus_w.valid_in = 1'b0;
        bus_w.side_in  = 1'b0;
        bus_w.price_in = '0;
        bus_w.qty_in   = '0;
        bus_w.ts_in    = '0;
        bus_w.tx_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("rst_tx_last", 32'(bus.tx_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
        checkOutput("rst_next_id", 32'(next_order_id), 32'h0000);
        checkOutput("rst_next_id_w", 32'(next_order_id_w), 32'hFFFF);
        rst_n = 1'b1;
        tick();

        // Basic message and first-byte latency.
        push_literal();
        applyStimulus(1, 1, 24'h1234, 20'h10, 40'hABCD);
        tick();
        applyStimulus(0, 0, '0, '0, '0);
        checkOutput("latency_n1_valid", 32'(bus.tx_valid), 32'd0);
        tick();
        checkOutput("latency_n2_valid", 32'(bus.tx_valid), 32'd1);
        checkOutput("latency_n2_data", 32'(bus.tx_data), 32'hA5);
        drain(100);
        checkOutput("basic_next_id", 32'(next_order_id), 32'd1);

        // Order ID wrap on the second instance.
        bus_w.valid_in = 1'b1;
        bus_w.side_in  = 1'b1;
        bus_w.price_in = 24'h1234;
        bus_w.qty_in   = 20'h10;
        bus_w.ts_in    = 40'hABCD;
        tick();
        bus_w.valid_in = 1'b0;
        repeat (MSG_LEN + 4) tick();
        bus_w.valid_in = 1'b1;
        tick();
        bus_w.valid_in = 1'b0;
        repeat (MSG_LEN + 4) tick();
        checkOutput("wrap_len", 32'(w_bytes.size()), 32'(2 * MSG_LEN));
        if (w_bytes.size() >= 2 * MSG_LEN) begin
            checkOutput("wrap_id0_hi", 32'(w_bytes[2]), 32'hFF);
            checkOutput("wrap_id0_lo", 32'(w_bytes[3]), 32'hFF);
            checkOutput("wrap_sync1", 32'(w_bytes[MSG_LEN]), 32'hA5);
            checkOutput("wrap_id1_hi", 32'(w_bytes[MSG_LEN + 2]), 32'h00);
            checkOutput("wrap_id1_lo", 32'(w_bytes[MSG_LEN + 3]), 32'h00);
        end
        checkOutput("wrap_next_id", 32'(next_order_id_w), 32'd1);

        // Backpressure: tx_ready low for 3 cycles after byte5 is accepted.
        do_reset();
        push_literal();
        applyStimulus(1, 1, 24'h1234, 20'h10, 40'hABCD);
        tick();
        applyStimulus(0, 0, '0, '0, '0);
        repeat (7) tick();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_data", 32'(bus.tx_data), 32'h12);
            checkOutput("stall_valid", 32'(bus.tx_valid), 32'd1);
            tick();
        end
        bus.tx_ready = 1'b1;
        drain(100);

        // Overflow: six back-to-back orders with the sink stalled.
        do_reset();
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k >= 1) checkOutput("ovf_drop_pulse", 32'(drop_pulse), (k == 6) ? 32'd1 : 32'd0);
            if (k < 6) begin
                rand_order(s, p, q, t);
                applyStimulus(1, s, p, q, t);
                if (k < 5) model_push(s, p, q, t);
            end else begin
                applyStimulus(0, 0, '0, '0, '0);
            end
            tick();
        end
        checkOutput("ovf_drop_count", 32'(drop_count), 32'd1);
        checkOutput("ovf_fifo_count", 32'(fifo_count), 32'd4);
        checkOutput("ovf_next_id", 32'(next_order_id), 32'd5);
        checkOutput("ovf_busy", 32'(busy), 32'd1);

        // Push during the idle bubble while full: the simultaneous pop makes room.
        bus.tx_ready = 1'b1;
        n = 0;
        while (completed_cnt < 1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("first_msg_done", 32'(completed_cnt >= 1), 32'd1);
        rand_order(s, p, q, t);
        applyStimulus(1, s, p, q, t);
        model_push(s, p, q, t);
        tick();
        applyStimulus(0, 0, '0, '0, '0);
        checkOutput("full_pushpop_drop", 32'(drop_pulse), 32'd0);
        checkOutput("full_pushpop_count", 32'(fifo_count), 32'd4);
        checkOutput("full_pushpop_next_id", 32'(next_order_id), 32'd6);
        drain(400);
        checkOutput("ovf_drop_count_final", 32'(drop_count), 32'd1);

        // Randomised traffic with random backpressure, never overfilling the FIFO.
        for (int c = 0; c < 400; c++) begin
            bus.tx_ready = ($urandom % 4) != 0;
            if ((accepted_cnt - completed_cnt) < DEPTH && ($urandom % 3) == 0) begin
                rand_order(s, p, q, t);
                applyStimulus(1, s, p, q, t);
                model_push(s, p, q, t);
            end else begin
                applyStimulus(0, 0, '0, '0, '0);
            end
            tick();
        end
        applyStimulus(0, 0, '0, '0, '0);
        bus.tx_ready = 1'b1;
        drain(400);
        checkOutput("rand_next_id", 32'(next_order_id), 32'(model_id));
        checkOutput("rand_drop_count", 32'(drop_count), 32'd1);

        // Reset in the middle of a message, with a second order still queued.
        rand_order(s, p, q, t);
        applyStimulus(1, s, p, q, t);
        model_push(s, p, q, t);
        tick();
        rand_order(s, p, q, t);
        applyStimulus(1, s, p, q, t);
        model_push(s, p, q, t);
        tick();
        applyStimulus(0, 0, '0, '0, '0);
        repeat (8) tick();
        checkOutput("pre_reset_remaining", 32'(exp_data.size()), 32'(2 * MSG_LEN - 8));
        checkOutput("pre_reset_fifo", 32'(fifo_count), 32'd1);
        rst_n = 1'b0;
        model_flush();
        #1;
        checkOutput("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_drop_count", 32'(drop_count), 32'd0);
        checkOutput("mid_rst_next_id", 32'(next_order_id), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        push_literal();
        applyStimulus(1, 1, 24'h1234, 20'h10, 40'hABCD);
        tick();
        applyStimulus(0, 0, '0, '0, '0);
        tick();
        checkOutput("post_rst_first_data", 32'(bus.tx_data), 32'hA5);
        drain(100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
